product_accumulator: RTL

- Sequential multiply-accumulate back end that sits directly downstream of the 16x16 signed Booth/Wallace multiplier.
- Accepts a stream of signed 32-bit products over a valid/ready handshake and sums them in a wide internal accumulator.
- On a last-flagged beat, or on a forced flush, presents one saturated 32-bit result with an overflow flag and a beat count.
- Dot-product and FIR-tap sums are built from multiplier outputs with this block.

---
 rtl/product_accumulator.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//
// Purpose:
//   Multiply-accumulate back end for the 16x16 signed multiplier. Signed
//   PROD_W-bit products arrive over a valid/ready stream and are summed in
//   an ACC_W-bit accumulator. A sum closes on a beat with in_last set, or
//   when it reaches 2^CNT_W-1 beats (forced flush). The closed sum is
//   presented once as a saturated OUT_W-bit result, together with the beat
//   count and an overflow flag, and is held until downstream takes it.
//
// Optional feature (macro MACC_ROUND_EN):
//   When defined, the result is (acc + 2^(SHIFT-1)) >>> SHIFT (round half
//   up) before saturation. When undefined, the result is the saturated
//   accumulator and SHIFT has no effect.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous abort back to IDLE (highest priority)
//   in_valid   in   product beat valid
//   in_ready   out  block can accept a beat (low only in HOLD)
//   in_prod    in   signed product [PROD_W-1:0]
//   in_last    in   beat closes the current sum
//   out_valid  out  result valid
//   out_ready  in   downstream accepts the result
//   out_sum    out  saturated signed result [OUT_W-1:0]
//   out_count  out  number of beats in the result [CNT_W-1:0]
//   out_ovf    out  out_sum was saturated
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid and ready are both high; valid, once raised, holds its payload
// stable until that transfer (or until clear/reset).
//
// FSM state is held in the enum register `state` (S_IDLE / S_ACC / S_HOLD)
// so checkers can bind to it by name.
// ---------------------------------------------------------------------------
module product_accumulator #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 32,
    parameter int CNT_W  = 8,
    parameter int SHIFT  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    // Elaboration-time configuration check.
    if (ACC_W < PROD_W + CNT_W || ACC_W < OUT_W || SHIFT < 1 || SHIFT >= ACC_W) begin : g_cfg_error
        $error("product_accumulator: invalid parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturation bounds expressed at ACC_W+1 bits, built by concatenation
    // so no 32-bit integer arithmetic can overflow for OUT_W = 32.
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN =
        {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    localparam logic [OUT_W-1:0] OUT_POS_SAT = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_NEG_SAT = {1'b1, {(OUT_W-1){1'b0}}};

    state_t                   state;
    state_t                   state_nxt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic signed [ACC_W-1:0]  prod_ext;
    logic [CNT_W-1:0]         count;
    logic [CNT_W-1:0]         count_nxt;
    logic                     beat;
    logic                     res_xfer;
    logic                     close_sum;
    logic signed [ACC_W:0]    acc_wide;
    logic signed [ACC_W:0]    res_wide;
    logic [OUT_W-1:0]         sum_sat;
    logic                     ovf_sat;

    assign beat     = in_valid & in_ready;
    assign res_xfer = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Accumulator arithmetic for the beat being offered this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        prod_ext  = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
        acc_nxt   = prod_ext;
        count_nxt = CNT_W'(1);
        if (state == S_ACC) begin
            acc_nxt   = acc + prod_ext;
            count_nxt = count + CNT_W'(1);
        end
    end

    // A sum closes on in_last, or when the ACC beat fills the counter.
    assign close_sum = beat & (in_last | ((state == S_ACC) & (count_nxt == CNT_MAX)));

    // ------------------------------------------------------------------
    // Result shaping: optional rounding shift, then saturation.
    // ------------------------------------------------------------------
    always_comb begin
        acc_wide = {acc_nxt[ACC_W-1], acc_nxt};
`ifdef MACC_ROUND_EN
        // One extra bit of headroom keeps the rounding add from wrapping.
        res_wide = (acc_wide + ({{ACC_W{1'b0}}, 1'b1} << (SHIFT-1))) >>> SHIFT;
`else
        res_wide = acc_wide;
`endif
        sum_sat = res_wide[OUT_W-1:0];
        ovf_sat = 1'b0;
        if (res_wide > SAT_MAX) begin
            sum_sat = OUT_POS_SAT;
            ovf_sat = 1'b1;
        end else if (res_wide < SAT_MIN) begin
            sum_sat = OUT_NEG_SAT;
            ovf_sat = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ACC: begin
                if (beat) begin
                    state_nxt = close_sum ? S_HOLD : S_ACC;
                end
            end
            S_HOLD: begin
                if (res_xfer) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (clear) begin
            state_nxt = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = (state != S_HOLD);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (clear) begin
            // Result fields keep their last values; only the live sum and
            // the pending-result flag are dropped.
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (beat) begin
                acc   <= acc_nxt;
                count <= count_nxt;
            end
            if (close_sum) begin
                out_sum   <= sum_sat;
                out_count <= count_nxt;
                out_ovf   <= ovf_sat;
                out_valid <= 1'b1;
            end else if (res_xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
